wb_ram_responder: RTL and testbench

- Wishbone B4 pipelined responder (slave) fronting the internal on-chip RAM window at 0xb0000000. The CPU boots and places its stack in this window.
- It is the far end of the CPU's cyc/stb/we/ack/stall bus. It accepts one request at a time, inserts a programmable number of wait states, then returns ack (or err) with read data.
- Word-addressed storage with byte-lane write enables.

---
 rtl/wb_ram_responder_if.sv | 39 +++
 rtl/wb_ram_responder.sv | 150 +++++++++++++++
 tb/tb_wb_ram_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_responder_if.sv
// Wishbone B4 pipelined bus bundle between the CPU (master) and the on-chip RAM responder (slave).
interface wb_ram_responder_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic        o_wb_stall;

    modport slave (
        input  i_wb_cyc,
        input  i_wb_stb,
        input  i_wb_we,
        input  i_wb_addr,
        input  i_wb_data,
        input  i_wb_sel,
        output o_wb_data,
        output o_wb_ack,
        output o_wb_err,
        output o_wb_stall
    );

    modport master (
        output i_wb_cyc,
        output i_wb_stb,
        output i_wb_we,
        output i_wb_addr,
        output i_wb_data,
        output i_wb_sel,
        input  o_wb_data,
        input  o_wb_ack,
        input  o_wb_err,
        input  o_wb_stall
    );
endinterface

// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined responder for the on-chip RAM window: one request in flight,
// programmable wait states, byte-lane writes, err on out-of-window or misaligned addresses.
module wb_ram_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'hb0000000,
    parameter int          ADDR_WIDTH  = 14,
    parameter int          WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    wb_ram_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam int         TAG_W     = 32 - ADDR_WIDTH - 2;
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [TAG_W-1:0] BASE_TAG = ADDR_BASE[31:ADDR_WIDTH+2];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  sel_reg;
    logic        we_reg;
    logic        ack_reg;
    logic        err_reg;
    logic        stall_reg;

    logic        accept;
    logic        wait_done;
    logic        commit;
    logic [31:0] cmt_addr;
    logic [31:0] cmt_wdata;
    logic [3:0]  cmt_sel;
    logic        cmt_we;
    logic        cmt_valid;
    logic [ADDR_WIDTH-1:0] cmt_index;
    logic        ram_wr;
    logic        ram_rd;
    logic [7:0]  rd_lane [4];

    assign accept    = bus.i_wb_cyc & bus.i_wb_stb & ~stall_reg;
    assign wait_done = (state_reg == ST_WAIT) & bus.i_wb_cyc & (cnt_reg == 4'd0);

    // With no wait states the accept edge is also the commit edge, so the request
    // is taken straight off the bus; otherwise the latched copy is used.
    assign commit    = NO_WAIT ? accept         : wait_done;
    assign cmt_addr  = NO_WAIT ? bus.i_wb_addr  : addr_reg;
    assign cmt_wdata = NO_WAIT ? bus.i_wb_data  : wdata_reg;
    assign cmt_sel   = NO_WAIT ? bus.i_wb_sel   : sel_reg;
    assign cmt_we    = NO_WAIT ? bus.i_wb_we    : we_reg;

    assign cmt_valid = (cmt_addr[31:ADDR_WIDTH+2] == BASE_TAG) && (cmt_addr[1:0] == 2'b00);
    assign cmt_index = cmt_addr[ADDR_WIDTH+1:2];
    assign ram_wr    = commit & cmt_valid & cmt_we;
    assign ram_rd    = commit & cmt_valid & ~cmt_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            sel_reg   <= 4'd0;
            we_reg    <= 1'b0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            stall_reg <= 1'b0;
        end else begin
            ack_reg <= commit & cmt_valid;
            err_reg <= commit & ~cmt_valid;

            if (accept) begin
                addr_reg  <= bus.i_wb_addr;
                wdata_reg <= bus.i_wb_data;
                sel_reg   <= bus.i_wb_sel;
                we_reg    <= bus.i_wb_we;
            end

            case (state_reg)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        if (NO_WAIT) begin
                            state_reg <= ST_RESP;
                            stall_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= WAIT_LOAD;
                            stall_reg <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                        stall_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Master abandoning the cycle aborts the request without a response.
                    if (!bus.i_wb_cyc) begin
                        state_reg <= ST_IDLE;
                        stall_reg <= 1'b0;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                        stall_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    stall_reg <= 1'b0;
                end
            endcase
        end
    end

    // One byte-wide memory per lane so each byte enable maps onto its own write port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (ram_wr && cmt_sel[gi]) begin
                    mem[cmt_index] <= cmt_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_reg <= 8'd0;
                end else if (ram_rd) begin
                    rd_reg <= mem[cmt_index];
                end
            end

            assign rd_lane[gi] = rd_reg;
        end
    endgenerate

    assign bus.o_wb_data  = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
    assign bus.o_wb_ack   = ack_reg;
    assign bus.o_wb_err   = err_reg;
    assign bus.o_wb_stall = stall_reg;
endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder with three instances at 0, 1 and 3 wait states.
module tb_wb_ram_responder;
    localparam int K0 = 0;  // WAIT_STATES = 0
    localparam int K1 = 1;  // WAIT_STATES = 1
    localparam int K3 = 2;  // WAIT_STATES = 3

    logic        clk;
    logic        reset;
    logic [2:0]  cyc, stb, we;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  sel   [3];
    logic [2:0]  ack, err, stall;
    logic [31:0] rdata [3];

    int n_vec;
    int n_err;

    wb_ram_responder_if bus_ws0 ();
    wb_ram_responder_if bus_ws1 ();
    wb_ram_responder_if bus_ws3 ();

    wb_ram_responder #(.ADDR_BASE(32'hb0000000), .ADDR_WIDTH(14), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .bus(bus_ws0));
    wb_ram_responder #(.ADDR_BASE(32'hb0000000), .ADDR_WIDTH(14), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .bus(bus_ws1));
    wb_ram_responder #(.ADDR_BASE(32'hb0000000), .ADDR_WIDTH(14), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .bus(bus_ws3));

    assign bus_ws0.i_wb_cyc  = cyc[K0];
    assign bus_ws0.i_wb_stb  = stb[K0];
    assign bus_ws0.i_wb_we   = we[K0];
    assign bus_ws0.i_wb_addr = addr[K0];
    assign bus_ws0.i_wb_data = wdata[K0];
    assign bus_ws0.i_wb_sel  = sel[K0];
    assign ack[K0]   = bus_ws0.o_wb_ack;
    assign err[K0]   = bus_ws0.o_wb_err;
    assign stall[K0] = bus_ws0.o_wb_stall;
    assign rdata[K0] = bus_ws0.o_wb_data;

    assign bus_ws1.i_wb_cyc  = cyc[K1];
    assign bus_ws1.i_wb_stb  = stb[K1];
    assign bus_ws1.i_wb_we   = we[K1];
    assign bus_ws1.i_wb_addr = addr[K1];
    assign bus_ws1.i_wb_data = wdata[K1];
    assign bus_ws1.i_wb_sel  = sel[K1];
    assign ack[K1]   = bus_ws1.o_wb_ack;
    assign err[K1]   = bus_ws1.o_wb_err;
    assign stall[K1] = bus_ws1.o_wb_stall;
    assign rdata[K1] = bus_ws1.o_wb_data;

    assign bus_ws3.i_wb_cyc  = cyc[K3];
    assign bus_ws3.i_wb_stb  = stb[K3];
    assign bus_ws3.i_wb_we   = we[K3];
    assign bus_ws3.i_wb_addr = addr[K3];
    assign bus_ws3.i_wb_data = wdata[K3];
    assign bus_ws3.i_wb_sel  = sel[K3];
    assign ack[K3]   = bus_ws3.o_wb_ack;
    assign err[K3]   = bus_ws3.o_wb_err;
    assign stall[K3] = bus_ws3.o_wb_stall;
    assign rdata[K3] = bus_ws3.o_wb_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request on instance k; waits at most 'budget' edges for ack/err.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic got_ack, output logic got_err,
                        output logic [31:0] got_data, output int lat, output logic stall_mid);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; sel[k] = s;
        step();
        lat = 1;
        stall_mid = stall[k];
        stb[k] = 1'b0;
        while (!(ack[k] | err[k]) && lat < 10) begin
            step();
            lat++;
        end
        got_ack = ack[k]; got_err = err[k]; got_data = rdata[k];
        $display("xfer inst=%0d we=%0b addr=%h wdata=%h sel=%h -> ack=%0b err=%0b data=%h lat=%0d",
                 k, w, a, d, s, got_ack, got_err, got_data, lat);
        cyc[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; addr[k] = 0; wdata[k] = 0; sel[k] = 0;
        end
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({ack[k], err[k], stall[k]} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_ctrl inst=%0d: got ack/err/stall=%b expected 000", k, {ack[k], err[k], stall[k]});
            end
            n_vec++;
            if (rdata[k] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_data inst=%0d: got %h expected 00000000", k, rdata[k]);
            end
        end
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_write_read_ws1();
        logic a, e, sm; logic [31:0] d; int lat;
        xfer(K1, 1'b1, 32'hb0000010, 32'hdeadbeef, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (!(a === 1'b1 && e === 1'b0 && lat == 2 && sm === 1'b1)) begin
            n_err++;
            $display("FAIL ws1_write: got ack=%b err=%b lat=%0d stall_mid=%b expected ack=1 err=0 lat=2 stall_mid=1", a, e, lat, sm);
        end
        xfer(K1, 1'b0, 32'hb0000010, 32'h0, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (!(a === 1'b1 && lat == 2 && d === 32'hdeadbeef)) begin
            n_err++;
            $display("FAIL ws1_read: got ack=%b lat=%0d data=%h expected ack=1 lat=2 data=deadbeef", a, lat, d);
        end
        step();
        n_vec++;
        if (ack[K1] !== 1'b0 || rdata[K1] !== 32'hdeadbeef) begin
            n_err++;
            $display("FAIL ws1_hold: got ack=%b data=%h expected ack=0 data=deadbeef", ack[K1], rdata[K1]);
        end
    endtask

    task automatic test_partial_write();
        logic a, e, sm; logic [31:0] d; int lat;
        xfer(K1, 1'b1, 32'hb0000010, 32'h11223344, 4'b0101, a, e, d, lat, sm);
        n_vec++;
        if (a !== 1'b1 || d !== 32'hdeadbeef) begin
            n_err++;
            $display("FAIL partial_write: got ack=%b data=%h expected ack=1 data=deadbeef (held)", a, d);
        end
        xfer(K1, 1'b0, 32'hb0000010, 32'h0, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (a !== 1'b1 || d !== 32'hde22be44) begin
            n_err++;
            $display("FAIL partial_read: got ack=%b data=%h expected ack=1 data=de22be44", a, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_tab [3];
        logic [31:0] d_tab [3];
        a_tab[0] = 32'hb0000000; a_tab[1] = 32'hb0000004; a_tab[2] = 32'hb000fffc;
        d_tab[0] = 32'h12345678; d_tab[1] = 32'h9abcdef0; d_tab[2] = 32'h0badf00d;
        cyc[K0] = 1'b1; stb[K0] = 1'b1; sel[K0] = 4'hf;
        for (int i = 0; i < 6; i++) begin
            we[K0] = (i < 3);
            addr[K0] = a_tab[i % 3];
            wdata[K0] = (i < 3) ? d_tab[i % 3] : 32'h0;
            step();
            $display("b2b cycle=%0d we=%0b addr=%h -> ack=%0b stall=%0b data=%h", i, we[K0], addr[K0], ack[K0], stall[K0], rdata[K0]);
            n_vec++;
            if (ack[K0] !== 1'b1 || stall[K0] !== 1'b0 || err[K0] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ctrl cycle=%0d: got ack=%b stall=%b err=%b expected 1 0 0", i, ack[K0], stall[K0], err[K0]);
            end
            if (i >= 3) begin
                n_vec++;
                if (rdata[K0] !== d_tab[i - 3]) begin
                    n_err++;
                    $display("FAIL b2b_data cycle=%0d: got %h expected %h", i, rdata[K0], d_tab[i - 3]);
                end
            end
        end
        cyc[K0] = 1'b0; stb[K0] = 1'b0;
        step();
        n_vec++;
        if (ack[K0] !== 1'b0 || rdata[K0] !== 32'h0badf00d) begin
            n_err++;
            $display("FAIL b2b_idle: got ack=%b data=%h expected ack=0 data=0badf00d", ack[K0], rdata[K0]);
        end
    endtask

    task automatic test_stb_without_cyc();
        cyc[K1] = 1'b0; stb[K1] = 1'b1; we[K1] = 1'b1; addr[K1] = 32'hb0000010;
        wdata[K1] = 32'h0; sel[K1] = 4'hf;
        repeat (3) begin
            step();
            n_vec++;
            if ({ack[K1], err[K1], stall[K1]} !== 3'b000) begin
                n_err++;
                $display("FAIL stb_no_cyc: got ack/err/stall=%b expected 000", {ack[K1], err[K1], stall[K1]});
            end
        end
        stb[K1] = 1'b0;
    endtask

    task automatic test_err();
        logic a, e, sm; logic [31:0] d; int lat;
        logic [31:0] bad_addr [4];
        logic [3:0]  bad_we;
        bad_addr[0] = 32'hb0010000; bad_addr[1] = 32'hb0000002;
        bad_addr[2] = 32'hb0010010; bad_addr[3] = 32'hb0000012;
        bad_we = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            xfer(K1, bad_we[i], bad_addr[i], 32'h0, 4'hf, a, e, d, lat, sm);
            n_vec++;
            if (!(e === 1'b1 && a === 1'b0 && lat == 2 && d === 32'hde22be44)) begin
                n_err++;
                $display("FAIL err_resp addr=%h: got ack=%b err=%b lat=%0d data=%h expected ack=0 err=1 lat=2 data=de22be44",
                         bad_addr[i], a, e, lat, d);
            end
        end
        xfer(K1, 1'b0, 32'hb0000010, 32'h0, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0 || d !== 32'hde22be44) begin
            n_err++;
            $display("FAIL err_after_read: got ack=%b err=%b data=%h expected ack=1 err=0 data=de22be44", a, e, d);
        end
    endtask

    task automatic test_abort_ws3();
        logic a, e, sm; logic [31:0] d; int lat;
        xfer(K3, 1'b1, 32'hb0000020, 32'h55aa55aa, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (a !== 1'b1 || lat != 4 || sm !== 1'b1) begin
            n_err++;
            $display("FAIL ws3_write: got ack=%b lat=%0d stall_mid=%b expected ack=1 lat=4 stall_mid=1", a, lat, sm);
        end
        cyc[K3] = 1'b1; stb[K3] = 1'b1; we[K3] = 1'b1; addr[K3] = 32'hb0000020;
        wdata[K3] = 32'hcafef00d; sel[K3] = 4'hf;
        step();
        stb[K3] = 1'b0;
        step();
        cyc[K3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("abort cycle=%0d -> ack=%0b err=%0b stall=%0b", i, ack[K3], err[K3], stall[K3]);
            n_vec++;
            if ({ack[K3], err[K3], stall[K3]} !== 3'b000) begin
                n_err++;
                $display("FAIL abort_idle cycle=%0d: got ack/err/stall=%b expected 000", i, {ack[K3], err[K3], stall[K3]});
            end
        end
        xfer(K3, 1'b0, 32'hb0000020, 32'h0, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (a !== 1'b1 || lat != 4 || d !== 32'h55aa55aa) begin
            n_err++;
            $display("FAIL abort_read: got ack=%b lat=%0d data=%h expected ack=1 lat=4 data=55aa55aa", a, lat, d);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic a, e, sm; logic [31:0] d; int lat;
        cyc[K3] = 1'b1; stb[K3] = 1'b1; we[K3] = 1'b1; addr[K3] = 32'hb0000020;
        wdata[K3] = 32'h77777777; sel[K3] = 4'hf;
        step();
        stb[K3] = 1'b0;
        step();
        n_vec++;
        if (stall[K3] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_stall: got %b expected 1", stall[K3]);
        end
        #2 reset = 1'b0;
        #1;
        $display("reset mid-wait -> ack=%0b err=%0b stall=%0b data=%h", ack[K3], err[K3], stall[K3], rdata[K3]);
        n_vec++;
        if ({ack[K3], err[K3], stall[K3]} !== 3'b000 || rdata[K3] !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_wait: got ack/err/stall=%b data=%h expected 000 data=00000000",
                     {ack[K3], err[K3], stall[K3]}, rdata[K3]);
        end
        cyc[K3] = 1'b0;
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (ack[K3] !== 1'b0 || err[K3] !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_resp cycle=%0d: got ack=%b err=%b expected 0 0", i, ack[K3], err[K3]);
            end
        end
        xfer(K3, 1'b0, 32'hb0000020, 32'h0, 4'hf, a, e, d, lat, sm);
        n_vec++;
        if (a !== 1'b1 || d !== 32'h55aa55aa) begin
            n_err++;
            $display("FAIL rst_write_dropped: got ack=%b data=%h expected ack=1 data=55aa55aa", a, d);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read_ws1();
        test_partial_write();
        test_back_to_back();
        test_stb_without_cyc();
        test_err();
        test_abort_ws3();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
